// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, format codes and the decoded-instruction payload
// shared by the decode stage and its combinational decoder.
package decode_pkg;

   // Widest supported datapath; the payload is sized for it and narrower
   // instances use the low bits.
   localparam int unsigned XLEN_MAX = 64;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef struct packed {
      logic [XLEN_MAX-1:0] pc;
      logic [6:0]          opcode;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      fmt_e                fmt;
      logic [XLEN_MAX-1:0] imm;
      logic                illegal;
      logic                is_zba;
   } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// decode_comb: pure field extraction, immediate generation and legality check.
// Zba encodings are accepted only when DECODE_ZBA_EN is defined.
module decode_comb
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 64
)
(
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   output decoded_t        dec
);

   localparam bit RV64 = (XLEN == 32'd64);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        zba_en;
   logic        sh_f3;
   logic        zba_sh;
   logic        zba_adduw;
   logic        zba_shuw;
   logic        zba_slliuw;
   logic        zba_hit;
   logic        f7_ok;
   logic        legal_opc;
   fmt_e        fmt;
   logic [31:0] imm32;

`ifdef DECODE_ZBA_EN
   assign zba_en = 1'b1;
`else
   assign zba_en = 1'b0;
`endif

   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];

   // Zba encoding recognition; the .uw forms exist only on RV64
   assign sh_f3      = (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
   assign zba_sh     = (opc == OPC_OP) && (f7 == 7'b0010000) && sh_f3;
   assign zba_adduw  = RV64 && (opc == OPC_OP_32) && (f7 == 7'b0000100) && (f3 == 3'b000);
   assign zba_shuw   = RV64 && (opc == OPC_OP_32) && (f7 == 7'b0010000) && sh_f3;
   assign zba_slliuw = RV64 && (opc == OPC_OP_IMM_32) && (instr[31:26] == 6'b000010)
                       && (f3 == 3'b001);
   assign zba_hit    = zba_sh || zba_adduw || zba_shuw || zba_slliuw;

   assign f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000) || (f7 == 7'b0000001);

   // Opcode legality and instruction format
   always_comb begin
      legal_opc = 1'b1;
      fmt       = FMT_R;
      case (opc)
         OPC_LUI, OPC_AUIPC:                   fmt = FMT_U;
         OPC_JAL:                              fmt = FMT_J;
         OPC_BRANCH:                           fmt = FMT_B;
         OPC_STORE:                            fmt = FMT_S;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM,
         OPC_MISC_MEM, OPC_SYSTEM:             fmt = FMT_I;
         OPC_OP:                               fmt = FMT_R;
         OPC_OP_IMM_32: begin
            fmt       = FMT_I;
            legal_opc = RV64;
         end
         OPC_OP_32:                            legal_opc = RV64;
         default:                              legal_opc = 1'b0;
      endcase
   end

   // 32-bit immediate for the format, sign bit always at instr[31]
   always_comb begin
      imm32 = 32'd0;
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'd0};
         FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         default: imm32 = 32'd0;
      endcase
   end

   // Assemble the decoded payload
   always_comb begin
      dec        = '0;
      dec.pc     = XLEN_MAX'(pc);
      dec.opcode = opc;
      dec.rd     = instr[11:7];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.funct3 = f3;
      dec.funct7 = f7;
      dec.fmt    = fmt;
      dec.imm    = {{32{imm32[31]}}, imm32};
      if (zba_en && zba_slliuw) begin
         dec.imm = XLEN_MAX'(instr[25:20]);
      end
      dec.is_zba  = zba_en && zba_hit;
      dec.illegal = (instr[1:0] != 2'b11) || !legal_opc
                    || (((opc == OPC_OP) || (opc == OPC_OP_32)) && !f7_ok
                        && !(zba_en && zba_hit))
                    || (zba_slliuw && !zba_en);
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with a two-entry skid buffer.
// Optional Zba support is enabled by defining DECODE_ZBA_EN.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 64
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal,
   output logic            out_is_zba
);

   if ((XLEN != 32'd32) && (XLEN != 32'd64)) begin : g_bad_xlen
      $error("decode_stage: XLEN must be 32 or 64");
   end

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e   state;
   decoded_t dec;
   decoded_t main_q;
   decoded_t skid_q;
   logic     accept;
   logic     issue;

   decode_comb #(.XLEN(XLEN)) u_decode_comb (
      .instr (in_instr),
      .pc    (in_pc),
      .dec   (dec)
   );

   assign accept = in_valid && in_ready;
   assign issue  = out_valid && out_ready;

   // Skid FSM: main register feeds the outputs, skid absorbs one stalled accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_q    <= dec;
                  state     <= ST_ONE;
                  out_valid <= 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && !issue) begin
                  skid_q   <= dec;
                  state    <= ST_TWO;
                  in_ready <= 1'b0;
               end else if (accept && issue) begin
                  main_q <= dec;
               end else if (issue) begin
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
               end
            end
            ST_TWO: begin
               if (issue) begin
                  main_q   <= skid_q;
                  state    <= ST_ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_pc      = main_q.pc[XLEN-1:0];
   assign out_opcode  = main_q.opcode;
   assign out_rd      = main_q.rd;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_funct3  = main_q.funct3;
   assign out_funct7  = main_q.funct7;
   assign out_fmt     = main_q.fmt;
   assign out_imm     = main_q.imm[XLEN-1:0];
   assign out_illegal = main_q.illegal;
   assign out_is_zba  = main_q.is_zba;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: RV64 and RV32 instances driven in lockstep, checked against
// a queue-based handshake model and an arithmetic decode reference.
module tb_decode_stage;

`ifdef DECODE_ZBA_EN
   localparam bit ZBA = 1'b1;
`else
   localparam bit ZBA = 1'b0;
`endif

   localparam logic [6:0] LOAD = 7'h03, MISC = 7'h0F, OPIMM = 7'h13, AUIPC = 7'h17,
                          OPIMM32 = 7'h1B, STORE = 7'h23, OP = 7'h33, LUI = 7'h37,
                          OP32 = 7'h3B, BRANCH = 7'h63, JALR = 7'h67, JAL = 7'h6F,
                          SYSTEM = 7'h73;
   localparam logic [6:0] OPCS [14] = '{LOAD, MISC, OPIMM, AUIPC, OPIMM32, STORE, OP,
                                        LUI, OP32, BRANCH, JALR, JAL, SYSTEM, 7'h5B};

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [2:0]  fmt;
      logic [63:0] imm;
      logic        illegal;
      logic        is_zba;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        a_in_ready, a_out_valid, a_illegal, a_zba;
   logic [63:0] a_pc, a_imm;
   logic [6:0]  a_opcode, a_f7;
   logic [4:0]  a_rd, a_rs1, a_rs2;
   logic [2:0]  a_f3, a_fmt;

   logic        b_in_ready, b_out_valid, b_illegal, b_zba;
   logic [31:0] b_pc, b_imm;
   logic [6:0]  b_opcode, b_f7;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic [2:0]  b_f3, b_fmt;

   int n_checks = 0;
   int n_errors = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_pc), .out_opcode(a_opcode), .out_rd(a_rd), .out_rs1(a_rs1),
      .out_rs2(a_rs2), .out_funct3(a_f3), .out_funct7(a_f7), .out_fmt(a_fmt),
      .out_imm(a_imm), .out_illegal(a_illegal), .out_is_zba(a_zba)
   );

   decode_stage #(.XLEN(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_pc(b_pc), .out_opcode(b_opcode), .out_rd(b_rd),
      .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_f3), .out_funct7(b_f7),
      .out_fmt(b_fmt), .out_imm(b_imm), .out_illegal(b_illegal), .out_is_zba(b_zba)
   );

   // Single comparison point: counts every check, reports each mismatch
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference decode from the ISA rules, computed with signed arithmetic
   function automatic exp_t ref_decode(input logic [31:0] ins, input bit is64);
      exp_t        e;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      bit          legal_op, shn, slliuw, zba_enc, bad_f7;
      longint      v;
      e  = '0;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      e.opcode = op;
      e.rd = ins[11:7];
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.funct3 = f3;
      e.funct7 = f7;
      case (op)
         JALR, LOAD, OPIMM, OPIMM32, MISC, SYSTEM: e.fmt = 3'd1;
         STORE:      e.fmt = 3'd2;
         BRANCH:     e.fmt = 3'd3;
         LUI, AUIPC: e.fmt = 3'd4;
         JAL:        e.fmt = 3'd5;
         default:    e.fmt = 3'd0;
      endcase
      legal_op = (op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC,
                             SYSTEM}) || (is64 && (op inside {OPIMM32, OP32}));
      shn     = f3 inside {3'd2, 3'd4, 3'd6};
      slliuw  = is64 && op == OPIMM32 && ins[31:26] == 6'b000010 && f3 == 3'd1;
      zba_enc = (op == OP && f7 == 7'h10 && shn) || slliuw ||
                (is64 && op == OP32 && ((f7 == 7'h04 && f3 == 3'd0) || (f7 == 7'h10 && shn)));
      bad_f7  = (op == OP || op == OP32) && !(f7 inside {7'h00, 7'h20, 7'h01});
      e.is_zba  = ZBA && zba_enc;
      e.illegal = (ins[1:0] != 2'b11) || !legal_op ||
                  (ZBA ? (bad_f7 && !zba_enc) : (bad_f7 || slliuw));
      case (e.fmt)
         3'd1:    v = longint'($signed(ins[31:20]));
         3'd2:    v = longint'($signed({ins[31:25], ins[11:7]}));
         3'd3:    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
         3'd4:    v = longint'($signed(ins[31:12])) * 4096;
         3'd5:    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
         default: v = 0;
      endcase
      if (ZBA && slliuw) v = longint'(ins[25:20]);
      if (!is64) v = v & 64'h0000_0000_FFFF_FFFF;
      e.imm = v;
      return e;
   endfunction

   task automatic check_fields(input string p, input exp_t e, input logic [63:0] epc,
                               input logic [63:0] pc, input logic [6:0] opc,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [2:0] fmt,
                               input logic [63:0] imm, input logic ill, input logic zba);
      check({p, ".pc"}, pc, epc);
      check({p, ".opcode"}, 64'(opc), 64'(e.opcode));
      check({p, ".rd"}, 64'(rd), 64'(e.rd));
      check({p, ".rs1"}, 64'(rs1), 64'(e.rs1));
      check({p, ".rs2"}, 64'(rs2), 64'(e.rs2));
      check({p, ".funct3"}, 64'(f3), 64'(e.funct3));
      check({p, ".funct7"}, 64'(f7), 64'(e.funct7));
      check({p, ".fmt"}, 64'(fmt), 64'(e.fmt));
      check({p, ".imm"}, imm, e.imm);
      check({p, ".illegal"}, 64'(ill), 64'(e.illegal));
      check({p, ".is_zba"}, 64'(zba), 64'(e.is_zba));
   endtask

   // Compare both instances against the model's queue head
   task automatic compare_all();
      check("d64.in_ready", 64'(a_in_ready), 64'(q.size() < 2));
      check("d32.in_ready", 64'(b_in_ready), 64'(q.size() < 2));
      check("d64.out_valid", 64'(a_out_valid), 64'(q.size() != 0));
      check("d32.out_valid", 64'(b_out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check_fields("d64", ref_decode(q[0].instr, 1'b1), q[0].pc, a_pc, a_opcode, a_rd,
                      a_rs1, a_rs2, a_f3, a_f7, a_fmt, a_imm, a_illegal, a_zba);
         check_fields("d32", ref_decode(q[0].instr, 1'b0), 64'(q[0].pc[31:0]), 64'(b_pc),
                      b_opcode, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_fmt, 64'(b_imm),
                      b_illegal, b_zba);
      end
   endtask

   // One clock: check, drive at negedge, update the model at the posedge
   task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                        input bit rdy, input bit fl);
      bit acc, iss;
      @(negedge clk);
      compare_all();
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      acc = v && (q.size() < 2);
      iss = rdy && (q.size() != 0);
      if (fl) begin
         q.delete();
      end else begin
         if (iss) void'(q.pop_front());
         if (acc) q.push_back('{ins, pc});
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [31:0] ins;
      op = OPCS[$urandom_range(0, 13)];
      f3 = 3'($urandom);
      case ($urandom_range(0, 5))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         2:       f7 = 7'h01;
         3:       f7 = 7'h10;
         4:       f7 = 7'h04;
         default: f7 = 7'($urandom);
      endcase
      ins = {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), op};
      if (op == OPIMM32 && $urandom_range(0, 1) == 1) begin
         ins[31:26] = 6'b000010;
         ins[14:12] = 3'b001;
      end
      if ($urandom_range(0, 15) == 0) ins[1:0] = 2'($urandom_range(0, 2));
      return ins;
   endfunction

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_instr = 32'd0;
      in_pc = 64'd0;
      repeat (2) @(negedge clk);
      check("rst.out_valid", 64'(a_out_valid), 64'd0);
      check("rst.in_ready", 64'(a_in_ready), 64'd1);
      check("rst.out_pc", a_pc, 64'd0);
      check("rst.out_imm", a_imm, 64'd0);
      rst = 1'b0;

      // Directed decodes with out_ready high
      cycle(1'b1, 32'hFFF0_0093, 64'h100, 1'b1, 1'b0);
      #1;
      check("addi.fmt", 64'(a_fmt), 64'd1);
      check("addi.imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi.rd", 64'(a_rd), 64'd1);
      check("addi.illegal", 64'(a_illegal), 64'd0);
      cycle(1'b1, 32'hFFDF_F06F, 64'h104, 1'b1, 1'b0);
      #1;
      check("jal.fmt", 64'(a_fmt), 64'd5);
      check("jal.imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      cycle(1'b1, 32'h8000_02B7, 64'h108, 1'b1, 1'b0);
      #1;
      check("lui32.imm", 64'(b_imm), 64'h8000_0000);
      cycle(1'b1, 32'h2020_C1B3, 64'h10C, 1'b1, 1'b0);
      #1;
      check("sh2add.is_zba", 64'(a_zba), 64'(ZBA));
      check("sh2add.illegal", 64'(a_illegal), 64'(!ZBA));
      cycle(1'b1, 32'h0820_81BB, 64'h110, 1'b1, 1'b0);
      #1;
      check("adduw32.illegal", 64'(b_illegal), 64'd1);
      cycle(1'b1, 32'h0000_0000, 64'h114, 1'b1, 1'b0);
      #1;
      check("zero.illegal", 64'(a_illegal), 64'd1);
      cycle(1'b1, 32'h0020_81BB, 64'h118, 1'b1, 1'b0);
      #1;
      check("addw32.illegal", 64'(b_illegal), 64'd1);
      check("addw64.illegal", 64'(a_illegal), 64'd0);
      cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

      // Back-pressure: three back-to-back, only two fit
      cycle(1'b1, 32'h0010_0093, 64'h200, 1'b0, 1'b0);
      cycle(1'b1, 32'h0020_0113, 64'h204, 1'b0, 1'b0);
      #1;
      check("bp.in_ready_low", 64'(a_in_ready), 64'd0);
      cycle(1'b1, 32'h0030_0193, 64'h208, 1'b0, 1'b0);
      #1;
      check("bp.hold_pc", a_pc, 64'h200);
      cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      #1;
      check("bp.second_pc", a_pc, 64'h204);
      check("bp.in_ready_back", 64'(a_in_ready), 64'd1);
      cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      #1;
      check("bp.drained", 64'(a_out_valid), 64'd0);

      // Flush in TWO overrides a concurrent input
      cycle(1'b1, 32'h0010_0093, 64'h300, 1'b0, 1'b0);
      cycle(1'b1, 32'h0020_0113, 64'h304, 1'b0, 1'b0);
      cycle(1'b1, 32'h0040_0213, 64'h308, 1'b0, 1'b1);
      #1;
      check("flush.out_valid", 64'(a_out_valid), 64'd0);
      check("flush.in_ready", 64'(a_in_ready), 64'd1);
      cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      #1;
      check("flush.dropped", 64'(a_out_valid), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 9) < 7, rand_instr(), {32'($urandom), 32'($urandom)},
               $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
      end

      // Asynchronous reset with both entries occupied
      cycle(1'b1, 32'hFFF0_0093, 64'h400, 1'b0, 1'b0);
      cycle(1'b1, 32'hFFDF_F06F, 64'h404, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst.out_valid", 64'(a_out_valid), 64'd0);
      check("arst.in_ready", 64'(a_in_ready), 64'd1);
      check("arst.out_pc", a_pc, 64'd0);
      check("arst.out_imm", a_imm, 64'd0);
      check("arst.out_rd", 64'(a_rd), 64'd0);
      check("arst.out_opcode", 64'(a_opcode), 64'd0);
      check("arst.d32_imm", 64'(b_imm), 64'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle($urandom_range(0, 1) == 1, rand_instr(), {32'($urandom), 32'($urandom)},
               1'b1, 1'b0);
      end
      cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
